// File: rtl/pipe_pkg.sv
// Shared pipeline types: IF/ID payload layout and address constants.
// Stage buffers size their payload from these types.
package pipe_pkg;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] branch_addr;
    logic              branch;
  } if_id_payload_t;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = '1;

endpackage

// File: rtl/pipe_ring_buf.sv
// Ring storage for the stage buffer.
// One write port, asynchronous read at rd_ptr.
module pipe_ring_buf #(
  parameter int DATA_W = 65,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipe_stage_buf.sv
// In-order skid buffer between pipeline stages.
// ts_ready is a function of registered occupancy only.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = $bits(if_id_payload_t),
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ls_valid,
  output logic                       ts_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       ts_valid,
  input  logic                       ns_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1))
      return '0;
    return p + PTR_W'(1);
  endfunction

  assign ts_valid = (occupancy != '0);
  assign ts_ready = (occupancy != OCC_W'(DEPTH));
  assign push = ls_valid & ts_ready & ~stall & ~flush;
  assign pop  = ts_valid & ns_ready & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (flush) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (!stall) begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Saturating count of cycles a valid payload sat frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall && ts_valid && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  pipe_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .we     (push),
    .wr_ptr (wr_ptr),
    .wdata  (in_data),
    .rd_ptr (rd_ptr),
    .rdata  (out_data)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && occupancy == OCC_W'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
    !(pop && occupancy == '0));
  a_occ_range: assert property (@(posedge clk) disable iff (!rst)
    occupancy <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf.
// DEPTH=2 instance for handshake scenarios, DEPTH=3 for wrap.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        ls_valid = 0, ns_ready = 0, stall = 0, flush = 0;
  logic [64:0] in_data = '0;
  logic        ts_ready, ts_valid;
  logic [64:0] out_data;
  logic [1:0]  occ;
  logic [15:0] scnt;

  logic        ls_valid3 = 0, ns_ready3 = 0, stall3 = 0, flush3 = 0;
  logic [64:0] in_data3 = '0;
  logic        ts_ready3, ts_valid3;
  logic [64:0] out_data3;
  logic [1:0]  occ3;
  logic [15:0] scnt3;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ts_ready(ts_ready),
    .in_data(in_data), .ts_valid(ts_valid),
    .ns_ready(ns_ready), .out_data(out_data),
    .stall(stall), .flush(flush),
    .occupancy(occ), .stall_cnt(scnt)
  );

  pipe_stage_buf #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid3), .ts_ready(ts_ready3),
    .in_data(in_data3), .ts_valid(ts_valid3),
    .ns_ready(ns_ready3), .out_data(out_data3),
    .stall(stall3), .flush(flush3),
    .occupancy(occ3), .stall_cnt(scnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    cmp++; if (ts_valid !== 1'b0) begin err++; $display("FAIL rst_valid got %0b want 0", ts_valid); end
    cmp++; if (ts_ready !== 1'b1) begin err++; $display("FAIL rst_ready got %0b want 1", ts_ready); end
    cmp++; if (occ !== 2'd0) begin err++; $display("FAIL rst_occ got %0d want 0", occ); end
    cmp++; if (out_data !== 65'd0) begin err++; $display("FAIL rst_data got %0h want 0", out_data); end
    cmp++; if (scnt !== 16'd0) begin err++; $display("FAIL rst_scnt got %0d want 0", scnt); end
  endtask

  task automatic test_streaming();
    ls_valid = 1; ns_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = 65'h100 + 65'(4 * i);
      tick();
      cmp++; if (out_data !== 65'h100 + 65'(4 * i)) begin err++; $display("FAIL stream_data[%0d] got %0h want %0h", i, out_data, 65'h100 + 65'(4 * i)); end
      cmp++; if (occ !== 2'd1 || ts_valid !== 1'b1) begin err++; $display("FAIL stream_occ[%0d] got %0d/%0b want 1/1", i, occ, ts_valid); end
    end
    ls_valid = 0;
    tick();
    cmp++; if (occ !== 2'd0) begin err++; $display("FAIL stream_drain got %0d want 0", occ); end
  endtask

  task automatic test_backpressure();
    ns_ready = 0; ls_valid = 1;
    in_data = 65'hA; tick();
    in_data = 65'hB; tick();
    cmp++; if (occ !== 2'd2) begin err++; $display("FAIL bp_occ got %0d want 2", occ); end
    cmp++; if (ts_ready !== 1'b0) begin err++; $display("FAIL bp_ready got %0b want 0", ts_ready); end
    in_data = 65'hC; tick();
    cmp++; if (occ !== 2'd2) begin err++; $display("FAIL bp_full_hold got %0d want 2", occ); end
    ls_valid = 0; ns_ready = 1;
    cmp++; if (out_data !== 65'hA) begin err++; $display("FAIL bp_first got %0h want a", out_data); end
    tick();
    cmp++; if (out_data !== 65'hB || occ !== 2'd1) begin err++; $display("FAIL bp_second got %0h/%0d want b/1", out_data, occ); end
    tick();
    cmp++; if (occ !== 2'd0) begin err++; $display("FAIL bp_drain got %0d want 0", occ); end
  endtask

  task automatic test_stall();
    ns_ready = 0; ls_valid = 1; in_data = 65'h55;
    tick();
    stall = 1; ns_ready = 1; in_data = 65'h66;
    repeat (4) tick();
    cmp++; if (out_data !== 65'h55) begin err++; $display("FAIL stall_data got %0h want 55", out_data); end
    cmp++; if (occ !== 2'd1) begin err++; $display("FAIL stall_occ got %0d want 1", occ); end
    cmp++; if (scnt !== 16'd4) begin err++; $display("FAIL stall_cnt got %0d want 4", scnt); end
    stall = 0; ls_valid = 0;
    tick();
    cmp++; if (occ !== 2'd0) begin err++; $display("FAIL stall_drain got %0d want 0", occ); end
  endtask

  task automatic test_flush();
    // wr_ptr is 1 here: 0x11 lands at index 1, 0x22 at index 0
    ns_ready = 0; ls_valid = 1;
    in_data = 65'h11; tick();
    in_data = 65'h22; tick();
    cmp++; if (occ !== 2'd2) begin err++; $display("FAIL fl_pre_occ got %0d want 2", occ); end
    flush = 1; stall = 1; in_data = 65'h33;
    tick();
    flush = 0; stall = 0; ls_valid = 0;
    cmp++; if (occ !== 2'd0 || ts_valid !== 1'b0 || ts_ready !== 1'b1) begin err++; $display("FAIL fl_state got occ=%0d v=%0b r=%0b want 0/0/1", occ, ts_valid, ts_ready); end
    cmp++; if (out_data !== 65'h22) begin err++; $display("FAIL fl_stale got %0h want 22", out_data); end
    cmp++; if (scnt !== 16'd5) begin err++; $display("FAIL fl_scnt got %0d want 5", scnt); end
    ls_valid = 1; in_data = 65'h44; tick();
    in_data = 65'h45; tick();
    ls_valid = 0;
    cmp++; if (out_data !== 65'h44 || occ !== 2'd2) begin err++; $display("FAIL fl_idx0 got %0h/%0d want 44/2", out_data, occ); end
    ns_ready = 1; tick();
    cmp++; if (out_data !== 65'h45) begin err++; $display("FAIL fl_next got %0h want 45", out_data); end
    tick();
    ns_ready = 0;
  endtask

  task automatic test_wrap3();
    logic [64:0] q[$];
    int sent = 0, got = 0, mocc = 0, cyc = 0;
    logic p, o;
    while (got < 10 && cyc < 300) begin
      ls_valid3 = (sent < 10);
      in_data3 = 65'h700 + 65'(sent);
      ns_ready3 = ($urandom_range(0, 2) != 0);
      cmp++; if (ts_ready3 !== (mocc != 3)) begin err++; $display("FAIL w3_ready c%0d got %0b occ=%0d", cyc, ts_ready3, mocc); end
      cmp++; if (ts_valid3 !== (mocc != 0)) begin err++; $display("FAIL w3_valid c%0d got %0b occ=%0d", cyc, ts_valid3, mocc); end
      if (mocc != 0) begin
        cmp++; if (out_data3 !== q[0]) begin err++; $display("FAIL w3_data c%0d got %0h want %0h", cyc, out_data3, q[0]); end
      end
      p = ls_valid3 && (mocc != 3);
      o = ns_ready3 && (mocc != 0);
      if (o) begin void'(q.pop_front()); got++; mocc--; end
      if (p) begin q.push_back(in_data3); sent++; mocc++; end
      tick();
      cyc++;
    end
    ls_valid3 = 0; ns_ready3 = 0;
    cmp++; if (got !== 10) begin err++; $display("FAIL w3_count got %0d want 10", got); end
    cmp++; if (occ3 !== 2'd0) begin err++; $display("FAIL w3_end_occ got %0d want 0", occ3); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_wrap3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
